// File: rtl/test_reg_wr_arbiter.sv
// test_reg_wr_arbiter: round-robin write arbiter driving a shared register with a write strobe and optional settle gap
module test_reg_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int SETTLE_CYCLES = 0,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [WIDTH-1:0]             data_out,
  output logic                         wr_pulse,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             wr_count
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int SCW = $clog2(SETTLE_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;
  state_t state;
  logic [GW-1:0] last_grant, nxt, idx;
  logic [SCW-1:0] cnt;
  // descending scan so the requester closest after last_grant is assigned last and wins
  always_comb begin
    nxt = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) nxt = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_out   <= '0;
      wr_pulse   <= 1'b0;
      grant_id   <= '0;
      req_ready  <= '0;
      busy       <= 1'b0;
      wr_count   <= '0;
      cnt        <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      wr_pulse <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant_id  <= nxt;
          req_ready <= NUM_REQ'(1) << nxt;
          busy      <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          req_ready <= '0;
          if (req_valid[grant_id]) begin
            data_out   <= req_data[int'(grant_id)*WIDTH +: WIDTH];
            wr_pulse   <= 1'b1;
            wr_count   <= wr_count + 1'b1;
            last_grant <= grant_id;
            cnt        <= SCW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
            state      <= SETTLE_CYCLES > 0 ? SETTLE : IDLE;
            busy       <= SETTLE_CYCLES > 0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
